// File: rtl/sd_card_spi_master_if.sv
// Command-engine side of the SD SPI byte master: byte request/ack handshake,
// per-transfer clock divider and chip-select request.
interface sd_card_spi_master_if;
   logic [15:0] clk_div;
   logic        nCS_ctrl;
   logic        spi_wr_req;
   logic        spi_wr_ack;
   logic [7:0]  spi_data_in;
   logic [7:0]  spi_data_out;

   modport master (
      output clk_div, nCS_ctrl, spi_wr_req, spi_data_in,
      input  spi_wr_ack, spi_data_out
   );

   modport slave (
      input  clk_div, nCS_ctrl, spi_wr_req, spi_data_in,
      output spi_wr_ack, spi_data_out
   );
endinterface

// File: rtl/sd_card_spi_master.sv
// Mode-0 SPI byte master for the SD card path: shifts one byte out MSB first
// while capturing MISO, then returns the received byte with a one-cycle ack.
module sd_card_spi_master (
   input  logic                  sys_clk,
   input  logic                  rst,
   sd_card_spi_master_if.slave   bus,
   output logic                  sd_sck,
   output logic                  sd_mosi,
   input  logic                  sd_miso,
   output logic                  sd_cs_n
);

   typedef enum logic [2:0] {IDLE, SHIFT, LAST_HALF, ACK, ACK_WAIT} state_t;

   state_t      r_state, w_next;
   logic [15:0] r_div_lat;
   logic [15:0] r_div_cnt;
   logic [3:0]  r_edge_cnt;
   logic [6:0]  r_tx;
   logic [7:0]  r_rx;
   logic [7:0]  r_data_out;
   logic        r_sck;
   logic        r_mosi;
   logic        r_cs_n;
   logic        w_tick;

   assign w_tick           = (r_div_cnt == r_div_lat);
   assign sd_sck           = r_sck;
   assign sd_mosi          = r_mosi;
   assign sd_cs_n          = r_cs_n;
   assign bus.spi_wr_ack   = (r_state == ACK);
   assign bus.spi_data_out = r_data_out;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (bus.spi_wr_req) w_next = SHIFT;
         SHIFT:     if (w_tick && r_edge_cnt == 4'd15) w_next = LAST_HALF;
         LAST_HALF: if (w_tick) w_next = ACK;
         ACK:       w_next = ACK_WAIT;
         ACK_WAIT:  w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // Chip select is a plain registered copy, deliberately outside the FSM.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) r_cs_n <= 1'b1;
      else     r_cs_n <= bus.nCS_ctrl;
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_div_lat  <= '0;
         r_div_cnt  <= '0;
         r_edge_cnt <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_data_out <= 8'h00;
         r_sck      <= 1'b0;
         r_mosi     <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_sck  <= 1'b0;
               r_mosi <= 1'b1;
               if (bus.spi_wr_req) begin
                  r_tx       <= bus.spi_data_in[6:0];
                  r_mosi     <= bus.spi_data_in[7];
                  r_div_lat  <= bus.clk_div;
                  r_div_cnt  <= '0;
                  r_edge_cnt <= '0;
               end
            end
            SHIFT: begin
               if (w_tick) begin
                  r_div_cnt  <= '0;
                  r_edge_cnt <= r_edge_cnt + 4'd1;
                  r_sck      <= ~r_sck;
                  if (!r_sck) begin
                     r_rx <= {r_rx[6:0], sd_miso};
                  end else if (r_edge_cnt != 4'd15) begin
                     // Last falling edge leaves bit 0 on MOSI through the hold phase.
                     r_mosi <= r_tx[6];
                     r_tx   <= {r_tx[5:0], 1'b0};
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 16'd1;
               end
            end
            LAST_HALF: begin
               if (w_tick) begin
                  r_div_cnt  <= '0;
                  r_data_out <= r_rx;
               end else begin
                  r_div_cnt <= r_div_cnt + 16'd1;
               end
            end
            ACK:      r_mosi <= 1'b1;
            ACK_WAIT: r_mosi <= 1'b1;
            default:  r_mosi <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_card_spi_master.sv
// Self-checking bench for sd_card_spi_master: transfers compared against a
// latency/byte reference computed from the transfer parameters.
module tb_sd_card_spi_master;

   logic        sys_clk = 1'b0;
   logic        rst     = 1'b1;
   logic        sd_sck, sd_mosi, sd_miso, sd_cs_n;
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          ack_cnt = 0;
   int          e_q[$];
   logic [7:0]  tx_q[$];
   logic [31:0] miso_word = 32'hFFFF_FFFF;
   logic [5:0]  rise_cnt  = '0;
   logic [7:0]  sh        = '0;
   logic        prev_sck  = 1'b0;

   sd_card_spi_master_if bus ();

   sd_card_spi_master dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus),
      .sd_sck  (sd_sck),
      .sd_mosi (sd_mosi),
      .sd_miso (sd_miso),
      .sd_cs_n (sd_cs_n)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc++;

   // Card model: next MISO bit is presented before each rising SCK.
   assign sd_miso = (rise_cnt < 6'd32) ? miso_word[5'd31 - rise_cnt[4:0]] : 1'b1;

   always @(posedge sd_sck) begin
      sh = {sh[6:0], sd_mosi};
      rise_cnt = rise_cnt + 6'd1;
      if (rise_cnt[2:0] == 3'd0) tx_q.push_back(sh);
   end

   always @(negedge sys_clk) begin
      if (sd_sck !== prev_sck) e_q.push_back(cyc);
      prev_sck = sd_sck;
      if (bus.spi_wr_ack === 1'b1) ack_cnt++;
   end

   task automatic clear_mon(input logic [31:0] mw);
      e_q.delete();
      tx_q.delete();
      rise_cnt  = '0;
      sh        = '0;
      miso_word = mw;
   endtask

   task automatic wait_ack(input int limit, input string nm, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge sys_clk);
         if (bus.spi_wr_ack === 1'b1) begin
            at = cyc;
            break;
         end
      end
      total++;
      if (at < 0) begin
         bad++;
         $display("FAIL %s ack_timeout got=none want=ack within %0d cycles", nm, limit);
      end
   endtask

   // One byte: div applies to this byte, clk_div is switched to new_div right after accept.
   task automatic xfer(input logic [7:0] d, input logic [15:0] div, input logic [15:0] new_div,
                       input logic [7:0] m, input string nm);
      int e0, at, per;
      per = int'(div) + 1;
      clear_mon({m, 24'hFFFFFF});
      @(negedge sys_clk);
      total++;
      if (sd_mosi !== 1'b1) begin bad++; $display("FAIL %s idle_mosi got=%b want=1", nm, sd_mosi); end
      bus.spi_data_in = d;
      bus.clk_div     = div;
      bus.spi_wr_req  = 1'b1;
      e0 = cyc + 1;
      @(negedge sys_clk);
      bus.spi_wr_req  = 1'b0;
      bus.clk_div     = new_div;
      bus.spi_data_in = ~d;
      wait_ack(17 * per + 40, nm, at);
      if (at < 0) return;
      total++;
      if (at - e0 !== 17 * per) begin
         bad++; $display("FAIL %s latency got=%0d want=%0d", nm, at - e0, 17 * per);
      end
      total++;
      if (bus.spi_data_out !== m) begin
         bad++; $display("FAIL %s data_out got=%h want=%h", nm, bus.spi_data_out, m);
      end
      total++;
      if (tx_q.size() != 1 || tx_q[0] !== d) begin
         bad++; $display("FAIL %s mosi_byte got=%h n=%0d want=%h", nm,
                         (tx_q.size() > 0) ? tx_q[0] : 8'hxx, tx_q.size(), d);
      end
      total++;
      if (e_q.size() != 16) begin
         bad++; $display("FAIL %s sck_edges got=%0d want=16", nm, e_q.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            total++;
            if (e_q[k] != e0 + (k + 1) * per) begin
               bad++; $display("FAIL %s sck_edge%0d got=%0d want=%0d", nm, k, e_q[k] - e0, (k + 1) * per);
            end
         end
      end
      @(negedge sys_clk);
      total++;
      if (bus.spi_wr_ack !== 1'b0) begin
         bad++; $display("FAIL %s ack_width got=%b want=0", nm, bus.spi_wr_ack);
      end
   endtask

   task automatic test_reset();
      bus.clk_div = 16'd0; bus.nCS_ctrl = 1'b0; bus.spi_wr_req = 1'b1; bus.spi_data_in = 8'h00;
      repeat (3) @(negedge sys_clk);
      total++;
      if ({sd_sck, sd_mosi, sd_cs_n, bus.spi_wr_ack, bus.spi_data_out} !== {4'b0110, 8'h00}) begin
         bad++; $display("FAIL reset_state got=%b%b%b%b/%h want=0110/00", sd_sck, sd_mosi, sd_cs_n,
                         bus.spi_wr_ack, bus.spi_data_out);
      end
      bus.spi_wr_req = 1'b0; bus.nCS_ctrl = 1'b1;
      rst = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic test_basic();
      xfer(8'hA5, 16'd0, 16'd0, 8'h3C, "basic_a5");
   endtask

   task automatic test_div3();
      xfer(8'h40, 16'd3, 16'd3, 8'(($urandom & 32'hFF) | 32'h1), "div3_40");
   endtask

   task automatic test_back_to_back();
      int at;
      logic [7:0] tx_exp[3];
      logic [7:0] rx_exp[3];
      tx_exp[0] = 8'hFF; tx_exp[1] = 8'h51; tx_exp[2] = 8'h00;
      for (int k = 0; k < 3; k++) rx_exp[k] = 8'($urandom);
      clear_mon({rx_exp[0], rx_exp[1], rx_exp[2], 8'hFF});
      ack_cnt = 0;
      @(negedge sys_clk);
      bus.clk_div = 16'd0; bus.spi_data_in = tx_exp[0]; bus.spi_wr_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_ack(80, "b2b", at);
         if (at < 0) break;
         total++;
         if (bus.spi_data_out !== rx_exp[k]) begin
            bad++; $display("FAIL b2b_rx%0d got=%h want=%h", k, bus.spi_data_out, rx_exp[k]);
         end
         @(negedge sys_clk);
         if (k < 2) bus.spi_data_in = tx_exp[k + 1];
         else       bus.spi_wr_req  = 1'b0;
      end
      repeat (60) @(negedge sys_clk);
      total++;
      if (ack_cnt != 3) begin bad++; $display("FAIL b2b_acks got=%0d want=3", ack_cnt); end
      total++;
      if (tx_q.size() != 3) begin
         bad++; $display("FAIL b2b_tx_count got=%0d want=3", tx_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if (tx_q[k] !== tx_exp[k]) begin
               bad++; $display("FAIL b2b_tx%0d got=%h want=%h", k, tx_q[k], tx_exp[k]);
            end
         end
      end
   endtask

   task automatic test_div_change();
      xfer(8'h9C, 16'd0, 16'd7, 8'($urandom), "divchg_cur");
      xfer(8'h2B, 16'd7, 16'd7, 8'($urandom), "divchg_next");
   endtask

   task automatic test_ncs();
      int n0;
      bus.nCS_ctrl = 1'b1;
      repeat (2) @(negedge sys_clk);
      n0 = e_q.size();
      bus.nCS_ctrl = 1'b0;
      #1;
      total++;
      if (sd_cs_n !== 1'b1) begin bad++; $display("FAIL ncs_delay got=%b want=1", sd_cs_n); end
      @(negedge sys_clk);
      total++;
      if (sd_cs_n !== 1'b0) begin bad++; $display("FAIL ncs_low got=%b want=0", sd_cs_n); end
      bus.nCS_ctrl = 1'b1;
      @(negedge sys_clk);
      total++;
      if (sd_cs_n !== 1'b1) begin bad++; $display("FAIL ncs_high got=%b want=1", sd_cs_n); end
      total++;
      if (e_q.size() != n0) begin bad++; $display("FAIL ncs_sck got=%0d edges want=0", e_q.size() - n0); end
   endtask

   task automatic test_rst_mid();
      int n0;
      bool_dummy: begin end
      bus.nCS_ctrl = 1'b0;
      clear_mon({8'hC3, 24'hFFFFFF});
      @(negedge sys_clk);
      bus.clk_div = 16'd1; bus.spi_data_in = 8'h6E; bus.spi_wr_req = 1'b1;
      @(negedge sys_clk);
      bus.spi_wr_req = 1'b0;
      for (int i = 0; i < 40 && rise_cnt < 6'd4; i++) @(negedge sys_clk);
      total++;
      if (sd_sck !== 1'b1 || rise_cnt != 6'd4) begin
         bad++; $display("FAIL rstmid_phase got=sck%b rises%0d want=sck1 rises4", sd_sck, rise_cnt);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({sd_sck, sd_mosi, sd_cs_n, bus.spi_data_out} !== {3'b011, 8'h00}) begin
         bad++; $display("FAIL rstmid_pins got=%b%b%b/%h want=011/00", sd_sck, sd_mosi, sd_cs_n, bus.spi_data_out);
      end
      bus.nCS_ctrl = 1'b1;
      @(negedge sys_clk);
      rst = 1'b0;
      n0 = ack_cnt;
      repeat (50) @(negedge sys_clk);
      total++;
      if (ack_cnt != n0) begin bad++; $display("FAIL rstmid_no_ack got=%0d want=0", ack_cnt - n0); end
      xfer(8'h5A, 16'd1, 16'd1, 8'h81, "rstmid_after");
   endtask

   task automatic test_random();
      logic [7:0]  d, m;
      logic [15:0] div;
      for (int t = 0; t < 6; t++) begin
         d   = 8'($urandom);
         m   = 8'($urandom);
         div = 16'($urandom_range(0, 4));
         xfer(d, div, 16'($urandom_range(0, 9)), m, "random");
      end
   endtask

   initial begin
      bus.clk_div = '0; bus.nCS_ctrl = 1'b1; bus.spi_wr_req = 1'b0; bus.spi_data_in = '0;
      test_reset();
      test_basic();
      test_div3();
      test_back_to_back();
      test_div_change();
      test_ncs();
      test_rst_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
